// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: streams sequential fetches into a small FIFO,
// with redirect flush, sticky halt and asynchronous reset.
module instr_fetch_queue #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       imemREN,
    output logic [31:0]                imemaddr,
    input  logic [31:0]                imemload,
    input  logic                       ihit,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       halt,
    input  logic                       deq,
    output logic                       valid,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          halted;
    logic          enq;
    logic          do_deq;

    logic [31:0]   mem_instr [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];

    always_comb begin
        imemaddr = fetch_pc;
        imemREN  = (count != FULL) && !halted;
        valid    = (count != '0);
        instr    = mem_instr[head];
        instr_pc = mem_pc[head];
        enq      = imemREN && ihit && !redirect;
        do_deq   = deq && valid && !redirect;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_pc <= PC_INIT;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            halted   <= 1'b0;
        end else begin
            if (halt)
                halted <= 1'b1;
            if (redirect) begin
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else begin
                if (enq) begin
                    tail     <= tail + PW'(1);
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (do_deq)
                    head <= head + PW'(1);
                if (enq && !do_deq)
                    count <= count + CW'(1);
                else if (!enq && do_deq)
                    count <= count - CW'(1);
            end
        end
    end

    // Entry storage is deliberately not reset; it is only observed while valid.
    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_instr[tail] <= imemload;
            mem_pc[tail]    <= fetch_pc;
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, which is the fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, which is the number of queue entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port imemREN, output, 1 bit: instruction memory read request.
REQ-006 SHALL have port imemaddr, output, 32 bits: instruction fetch address.
REQ-007 SHALL have port imemload, input, 32 bits: instruction word returned by the cache.
REQ-008 SHALL have port ihit, input, 1 bit: imemload is valid this cycle.
REQ-009 SHALL have port redirect, input, 1 bit: branch/jump taken; flush the queue and refetch.
REQ-010 SHALL have port redirect_pc, input, 32 bits: new fetch address, used when redirect=1.
REQ-011 SHALL have port halt, input, 1 bit: stop fetching (sticky).
REQ-012 SHALL have port deq, input, 1 bit: consumer takes the head entry.
REQ-013 SHALL have port valid, output, 1 bit: head entry present.
REQ-014 SHALL have port instr, output, 32 bits: head instruction word.
REQ-015 SHALL have port instr_pc, output, 32 bits: fetch address of the head instruction.
REQ-016 SHALL have port count, output, $clog2(DEPTH+1) bits: number of occupied entries.

Function
REQ-017 SHALL hold fetch_pc, a queue of DEPTH entries {instr, pc}, head/tail pointers, an occupancy counter and a halted flag.
REQ-018 SHALL drive imemaddr = fetch_pc combinationally at all times.
REQ-019 SHALL drive imemREN = (count != DEPTH) and not halted; there is no full-queue bypass, so imemREN=0 when full even if deq=1.
REQ-020 SHALL define enq = imemREN and ihit and not redirect; on enq, write {imemload, fetch_pc} at tail, advance tail, and set fetch_pc to fetch_pc + 4, modulo 2^32.
REQ-021 SHALL define do_deq = deq and valid and not redirect; on do_deq, advance head; deq while empty is ignored and changes nothing.
REQ-022 SHALL update count as follows: enq only +1; do_deq only -1; both, unchanged.
REQ-023 SHALL wrap the head and tail pointers modulo DEPTH.
REQ-024 SHALL, on redirect=1, have the next edge set count, head and tail to 0 and set fetch_pc to {redirect_pc[31:2], 2'b00}.
REQ-025 SHALL give redirect priority over enq and deq in the same cycle; a coincident ihit word is discarded.
REQ-026 SHALL drive valid = (count != 0), and drive instr and instr_pc combinationally from the head entry; their value is don't-care when valid=0.
REQ-027 SHALL set halted on the edge where halt=1 and clear it only by reset; once halted, no further enq occurs.
REQ-028 SHALL keep a halted queue draining normally via deq.
REQ-029 SHALL still apply redirect while halted (flush plus fetch_pc update), with imemREN remaining 0.
REQ-030 SHALL, when halt=1 and ihit coincide in one cycle, still enqueue that word, since imemREN was high in that cycle.

Reset
REQ-031 SHALL, while RST=1, immediately and asynchronously set fetch_pc=PC_INIT, count=0, head=tail=0 and halted=0.
REQ-032 SHALL, during and after reset, drive valid=0, count=0, imemaddr=PC_INIT and imemREN=1.
REQ-033 SHALL, on reset assertion mid-operation, discard all queued entries without waiting for a clock edge.
REQ-034 SHALL NOT reset the entry storage; its contents are unobservable while valid=0.

Verification
REQ-035 SHALL cover fill: DEPTH=4, ihit=1 every cycle, deq=0 -> entries hold pc 0,4,8,C; count=4; imemREN=0; fetch_pc=0x10.
REQ-036 SHALL cover steady stream: ihit=1 and deq=1 every cycle after the first -> count stays 1, and instr_pc increments by 4 each cycle.
REQ-037 SHALL cover redirect: queue holds 3 entries, redirect=1, redirect_pc=0x203, ihit=1, deq=1 in the same cycle -> next cycle count=0, valid=0, imemaddr=0x200; the coincident word is not enqueued.
REQ-038 SHALL cover wrap-around: 10 enq/deq cycles with DEPTH=4 -> FIFO order preserved across pointer wrap; a deq on an empty queue leaves count=0.
REQ-039 SHALL cover halt: halt=1 with 2 entries queued -> imemREN=0 thereafter; 2 deqs drain to valid=0; a later redirect updates imemaddr but imemREN stays 0.
REQ-040 SHALL cover asynchronous reset: RST pulsed between clock edges with count=3 -> count=0, valid=0 and imemaddr=PC_INIT before the next edge.
